sprite_blit: RTL and testbench
==============================

Name: sprite_blit

Overview:
- Parametrised sprite renderer, successor to the full-screen draw sequencer.
- On a start pulse it walks a SPR_W x SPR_H sprite stored in a synchronous ROM and emits one pixel per cycle to the vga_adapter write port at an arbitrary screen origin.
- Pixels falling off the right or bottom screen edge are clipped, and a colour key makes pixels transparent.
- A single instance serves the title page (full-screen, SPR_W=160, SPR_H=120) as well as ships, bullets and enemies.

Parameters:
- SPR_W, 16, sprite width in pixels (>=1)
- SPR_H, 16, sprite height in pixels (>=1)
- SCREEN_W, 160, visible screen width
- SCREEN_H, 120, visible screen height
- XW, 8, screen x coordinate width
- YW, 7, screen y coordinate width
- CW, 3, colour width
- ROM_LAT, 1, ROM read latency in cycles (>=1)
- TRANSP_EN, 1, 1 = suppress plot of key-coloured pixels
- TRANSP_COLOUR, 3'b000, key colour
- localparam AW = clog2(SPR_W*SPR_H), ROM address width

Ports:
- clk, input, 1, system clock (CLOCK_50)
- reset, input, 1, asynchronous, active-high
- start, input, 1, begin drawing; sampled only in IDLE
- x_in, input, XW, sprite origin x (left column)
- y_in, input, YW, sprite origin y (top row)
- rom_addr, output, AW, sprite ROM address, registered
- rom_data, input, CW, ROM colour, valid ROM_LAT cycles after rom_addr
- vga_x, output, XW, pixel x to vga_adapter
- vga_y, output, YW, pixel y to vga_adapter
- vga_colour, output, CW, pixel colour
- plot, output, 1, write strobe for the current pixel
- busy, output, 1, high from the cycle after start is accepted until done
- done, output, 1, one-cycle pulse after the final pixel slot

Behaviour:
- Reset (async, active-high): FSM=IDLE; all counters, pipeline valids and outputs cleared; plot=0, busy=0, done=0, rom_addr=0. Reset mid-draw aborts immediately, with no further plot or done.
- FSM states:
  - IDLE: start=1 latches x_in/y_in into origin registers, clears col/row, moves to RUN.
  - RUN: each cycle issues rom_addr = row*SPR_W + col (incremental counter, no multiplier) and pushes tag {valid, sx, sy} into a ROM_LAT-deep shift pipe.
    - col wraps at SPR_W-1, then row increments.
    - After issuing the address for (SPR_W-1, SPR_H-1), moves to DRAIN.
  - DRAIN: no new issues; waits ROM_LAT+1 cycles for the pipe to empty, then moves to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Origin registers are sampled once; changing x_in/y_in during RUN has no effect.
- start is ignored while busy (no queueing).
- Screen coordinates are computed as sx = origin_x + col and sy = origin_y + row in XW+1 / YW+1 bits, so there is no wrap-around.
- Output stage (registered), on the cycle the tag and rom_data meet: vga_x/vga_y/vga_colour are loaded from the tag and rom_data.
- plot = valid AND sx < SCREEN_W AND sy < SCREEN_H AND NOT (TRANSP_EN AND rom_data == TRANSP_COLOUR).
- When not plotting, vga_x/vga_y/vga_colour hold their previous values.
- Latency: start high in cycle 0 → rom_addr=0 in cycle 1 → plot for pixel (0,0) in cycle 2+ROM_LAT.
- Pixel slots are consecutive, with no bubbles: SPR_W*SPR_H slots in total.
- done pulses exactly one cycle after the last slot. busy rises in cycle 1 and falls in the same cycle done rises.
- A start arriving in the done cycle is ignored. A start in the cycle after done is accepted.
- Origin fully off-screen (x_in >= SCREEN_W): full traversal still occurs, plot is never asserted, and done still pulses.

Decomposition:
- Shared package holds:
  - screen constants SCREEN_W/SCREEN_H/XW/YW/CW
  - colour constants (COL_BLACK=3'b000 … COL_WHITE=3'b111)
  - the sprite-tag struct {valid, x, y}
- One sub-module: blit_tag_pipe, a parametrised ROM_LAT-deep shift register carrying the tag, with async clear.

Test Plan:
1. Defaults, ROM holds colour 3'b100 everywhere, start with x_in=10, y_in=20 → 256 plots. The first is (10,20) in cycle 3 and the last is (25,35); done pulses in cycle 259; busy spans cycles 1–258.
2. ROM checkerboard of 000/111, TRANSP_EN=1 → exactly 128 plots, all with colour 111; done timing identical to test 1.
3. Clipping, x_in=150, y_in=110 → only cols 0–9 and rows 0–9 plot (100 plots). Nothing with x>=160 or y>=120 is plotted; done is still at cycle 259.
4. ROM_LAT=3, SPR_W=4, SPR_H=2, origin (0,0) → rom_addr sequence 0..7 in cycles 1–8, plots in cycles 5–12, done in cycle 13.
5. Second start pulse at cycle 50 and x_in changed at cycle 60 during draw → both ignored; output identical to test 1.
6. reset asserted at cycle 100 mid-draw → plot/busy drop to 0 asynchronously and done never pulses. A new start after reset release produces the full sequence from (0,0).

Source files
------------

// File: rtl/sprite_blit_pkg.sv
// Shared screen constants, palette, FSM states and the pixel tag that rides
// alongside each ROM read.
package sprite_blit_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned XW       = 8;
    localparam int unsigned YW       = 7;
    localparam int unsigned CW       = 3;

    localparam logic [CW-1:0] COL_BLACK   = 3'b000;
    localparam logic [CW-1:0] COL_BLUE    = 3'b001;
    localparam logic [CW-1:0] COL_GREEN   = 3'b010;
    localparam logic [CW-1:0] COL_CYAN    = 3'b011;
    localparam logic [CW-1:0] COL_RED     = 3'b100;
    localparam logic [CW-1:0] COL_MAGENTA = 3'b101;
    localparam logic [CW-1:0] COL_YELLOW  = 3'b110;
    localparam logic [CW-1:0] COL_WHITE   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Screen coordinates carry one extra bit so origin+offset never wraps.
    typedef struct packed {
        logic          valid;
        logic [XW:0]   x;
        logic [YW:0]   y;
    } tag_t;

endpackage

// File: rtl/sprite_blit_if.sv
// Control, sprite ROM and vga_adapter write port of the sprite renderer.
interface sprite_blit_if #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7,
    parameter int unsigned CW = 3,
    parameter int unsigned AW = 8
);
    logic          start;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    logic [AW-1:0] rom_addr;
    logic [CW-1:0] rom_data;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          plot;
    logic          busy;
    logic          done;

    modport master (
        output start, x_in, y_in, rom_data,
        input  rom_addr, vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport slave (
        input  start, x_in, y_in, rom_data,
        output rom_addr, vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_blit_tag_pipe.sv
// Delays the pixel tag by the ROM latency so it meets the matching rom_data.
module blit_tag_pipe
    import sprite_blit_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t din,
    output tag_t dout
);
    tag_t pipe_q [DEPTH];
    tag_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < int'(DEPTH); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/sprite_blit.sv
// Sprite renderer: walks a SPR_W x SPR_H ROM sprite, one pixel per cycle,
// emitting clipped and colour-keyed plots at a latched screen origin.
module sprite_blit
    import sprite_blit_pkg::*;
#(
    parameter int unsigned SPR_W         = 16,
    parameter int unsigned SPR_H         = 16,
    parameter int unsigned SCREEN_W      = sprite_blit_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H      = sprite_blit_pkg::SCREEN_H,
    parameter int unsigned XW            = sprite_blit_pkg::XW,
    parameter int unsigned YW            = sprite_blit_pkg::YW,
    parameter int unsigned CW            = sprite_blit_pkg::CW,
    parameter int unsigned ROM_LAT       = 1,
    parameter bit          TRANSP_EN     = 1'b1,
    parameter logic [CW-1:0] TRANSP_COLOUR = COL_BLACK
) (
    input  logic        clk,
    input  logic        reset,
    sprite_blit_if.slave bus
);
    localparam int unsigned NPIX = SPR_W * SPR_H;
    localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned CXW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RYW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int unsigned DW   = $clog2(ROM_LAT + 2);

    state_e        state_q, state_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [CXW-1:0] col_q, col_d;
    logic [RYW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] drn_q, drn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          plot_q, plot_d;
    logic [XW-1:0] vx_q, vx_d;
    logic [YW-1:0] vy_q, vy_d;
    logic [CW-1:0] vc_q, vc_d;

    tag_t issue_c;
    tag_t tag_o;
    logic hit_c;

    // Tag for the address currently presented to the ROM.
    always_comb begin
        issue_c.valid = (state_q == S_RUN);
        issue_c.x     = (XW+1)'(ox_q) + (XW+1)'(col_q);
        issue_c.y     = (YW+1)'(oy_q) + (YW+1)'(row_q);
    end

    blit_tag_pipe #(.DEPTH(ROM_LAT)) u_pipe (
        .clk  (clk),
        .reset(reset),
        .din  (issue_c),
        .dout (tag_o)
    );

    always_comb begin
        hit_c = tag_o.valid
             && (tag_o.x < (XW+1)'(SCREEN_W))
             && (tag_o.y < (YW+1)'(SCREEN_H))
             && !(TRANSP_EN && (bus.rom_data == TRANSP_COLOUR));
    end

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        drn_d   = drn_q;
        plot_d  = hit_c;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ox_d    = bus.x_in;
                    oy_d    = bus.y_in;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (col_q == CXW'(SPR_W - 1)) begin
                    col_d = '0;
                    if (row_q == RYW'(SPR_H - 1)) begin
                        drn_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        row_d  = row_q + RYW'(1);
                        addr_d = addr_q + AW'(1);
                    end
                end else begin
                    col_d  = col_q + CXW'(1);
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drn_q == DW'(ROM_LAT)) begin
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (hit_c) begin
            vx_d = tag_o.x[XW-1:0];
            vy_d = tag_o.y[YW-1:0];
            vc_d = bus.rom_data;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            drn_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            plot_q  <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            drn_q   <= drn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            plot_q  <= plot_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
        end
    end

    assign bus.rom_addr   = addr_q;
    assign bus.vga_x      = vx_q;
    assign bus.vga_y      = vy_q;
    assign bus.vga_colour = vc_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: a default 16x16 instance and a small
// 4x2 instance with a 3-cycle ROM, checked against a per-cycle slot model.
module tb_sprite_blit;
    import sprite_blit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_blit_if #(.XW(8), .YW(7), .CW(3), .AW(8)) bus_a ();
    sprite_blit_if #(.XW(8), .YW(7), .CW(3), .AW(3)) bus_b ();

    sprite_blit dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    sprite_blit #(.SPR_W(4), .SPR_H(2), .ROM_LAT(3), .TRANSP_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    int n_vec = 0;
    int n_err = 0;
    int rom_mode = 0;

    // Sprite ROM contents for dut_a: solid red, or a white/black checkerboard.
    function automatic logic [2:0] rom_a(input logic [7:0] a);
        if (rom_mode == 0) return COL_RED;
        return (a[0] ^ a[4]) ? COL_WHITE : COL_BLACK;
    endfunction

    always_ff @(posedge clk) bus_a.rom_data <= rom_a(bus_a.rom_addr);

    logic [2:0] rb1, rb2;
    always_ff @(posedge clk) begin
        rb1 <= bus_b.rom_addr;
        rb2 <= rb1;
        bus_b.rom_data <= rb2;
    end

    int n_plot, n_slot_err, first_cyc, last_cyc, done_cyc, n_done;
    int busy_first, busy_last, n_busy, n_offscr, n_addr_err;
    int first_x, first_y, last_x, last_y;
    logic [2:0] col_and, col_or;
    logic async_plot, async_busy;

    // Runs one draw on dut_a from cycle 0 and records what happened per cycle.
    task automatic run_a(input int x0, input int y0, input int restart_cyc,
                         input int xchg_cyc, input int reset_cyc,
                         input bit acc2, input int ncyc);
        int base, k, ex, ey;
        logic [2:0] ec;
        bit exp_plot;
        n_plot = 0; n_slot_err = 0; first_cyc = -1; last_cyc = -1;
        done_cyc = -1; n_done = 0; busy_first = -1; busy_last = -1;
        n_busy = 0; n_offscr = 0; col_and = 3'b111; col_or = 3'b000;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        async_plot = 1'bx; async_busy = 1'bx;
        @(negedge clk);
        bus_a.x_in = 8'(x0);
        bus_a.y_in = 7'(y0);
        bus_a.start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            bus_a.start = (cyc == restart_cyc);
            if (cyc == xchg_cyc) bus_a.x_in = 8'(x0 + 7);
            if (reset_cyc > 0 && cyc == reset_cyc) begin
                reset = 1'b1;
                #1;
                async_plot = bus_a.plot;
                async_busy = bus_a.busy;
            end
            if (reset_cyc > 0 && cyc == reset_cyc + 5) reset = 1'b0;
            base = (acc2 && cyc >= restart_cyc + 3) ? restart_cyc : 0;
            k = cyc - base - 3;
            exp_plot = 1'b0; ex = 0; ey = 0; ec = 3'b000;
            if (k >= 0 && k < 256 && !(reset_cyc > 0 && cyc >= reset_cyc)) begin
                ex = x0 + k % 16;
                ey = y0 + k / 16;
                ec = rom_a(8'(k));
                exp_plot = (ex < 160) && (ey < 120) && (ec != 3'b000);
            end
            if (bus_a.plot !== exp_plot ||
                (exp_plot && (bus_a.vga_x !== 8'(ex) || bus_a.vga_y !== 7'(ey)
                              || bus_a.vga_colour !== ec)))
                n_slot_err++;
            if (bus_a.plot === 1'b1) begin
                n_plot++;
                if (first_cyc < 0) begin
                    first_cyc = cyc; first_x = int'(bus_a.vga_x); first_y = int'(bus_a.vga_y);
                end
                last_cyc = cyc; last_x = int'(bus_a.vga_x); last_y = int'(bus_a.vga_y);
                col_and &= bus_a.vga_colour;
                col_or  |= bus_a.vga_colour;
                if (bus_a.vga_x >= 8'd160 || bus_a.vga_y >= 7'd120) n_offscr++;
            end
            if (bus_a.done === 1'b1) begin n_done++; done_cyc = cyc; end
            if (bus_a.busy === 1'b1) begin
                n_busy++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
        end
    endtask

    task automatic test_reset_state();
        reset = 1'b1;
        bus_a.start = 1'b0; bus_a.x_in = '0; bus_a.y_in = '0;
        bus_b.start = 1'b0; bus_b.x_in = '0; bus_b.y_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus_a.plot, bus_a.busy, bus_a.done} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl_a: got %b expected 000", {bus_a.plot, bus_a.busy, bus_a.done});
        end
        n_vec++;
        if (bus_a.rom_addr !== 8'd0) begin
            n_err++; $display("FAIL reset_addr_a: got %0d expected 0", bus_a.rom_addr);
        end
        n_vec++;
        if ({bus_b.plot, bus_b.busy, bus_b.done, bus_b.rom_addr} !== 6'b0) begin
            n_err++; $display("FAIL reset_b: got %b expected 000000", {bus_b.plot, bus_b.busy, bus_b.done, bus_b.rom_addr});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus_a.busy !== 1'b0) begin
            n_err++; $display("FAIL idle_busy: got %b expected 0", bus_a.busy);
        end
    endtask

    task automatic test_solid();
        rom_mode = 0;
        run_a(10, 20, 0, 0, 0, 1'b0, 270);
        n_vec++; if (n_plot !== 256) begin n_err++; $display("FAIL solid_count: got %0d expected 256", n_plot); end
        n_vec++; if (n_slot_err !== 0) begin n_err++; $display("FAIL solid_slots: got %0d bad slots expected 0", n_slot_err); end
        n_vec++; if (first_cyc !== 3 || first_x !== 10 || first_y !== 20) begin
            n_err++; $display("FAIL solid_first: got c%0d (%0d,%0d) expected c3 (10,20)", first_cyc, first_x, first_y); end
        n_vec++; if (last_x !== 25 || last_y !== 35) begin
            n_err++; $display("FAIL solid_last: got (%0d,%0d) expected (25,35)", last_x, last_y); end
        n_vec++; if (done_cyc !== 259 || n_done !== 1) begin
            n_err++; $display("FAIL solid_done: got c%0d x%0d expected c259 x1", done_cyc, n_done); end
        n_vec++; if (busy_first !== 1 || busy_last !== 258 || n_busy !== 258) begin
            n_err++; $display("FAIL solid_busy: got %0d..%0d n%0d expected 1..258 n258", busy_first, busy_last, n_busy); end
        n_vec++; if (col_and !== 3'b100 || col_or !== 3'b100) begin
            n_err++; $display("FAIL solid_colour: got and %b or %b expected 100", col_and, col_or); end
    endtask

    task automatic test_transparency();
        rom_mode = 1;
        run_a(10, 20, 0, 0, 0, 1'b0, 270);
        n_vec++; if (n_plot !== 128) begin n_err++; $display("FAIL transp_count: got %0d expected 128", n_plot); end
        n_vec++; if (col_and !== 3'b111 || col_or !== 3'b111) begin
            n_err++; $display("FAIL transp_colour: got and %b or %b expected 111", col_and, col_or); end
        n_vec++; if (n_slot_err !== 0) begin n_err++; $display("FAIL transp_slots: got %0d expected 0", n_slot_err); end
        n_vec++; if (done_cyc !== 259) begin n_err++; $display("FAIL transp_done: got %0d expected 259", done_cyc); end
        rom_mode = 0;
    endtask

    task automatic test_clipping();
        rom_mode = 0;
        run_a(150, 110, 0, 0, 0, 1'b0, 270);
        n_vec++; if (n_plot !== 100) begin n_err++; $display("FAIL clip_count: got %0d expected 100", n_plot); end
        n_vec++; if (n_offscr !== 0) begin n_err++; $display("FAIL clip_offscreen: got %0d expected 0", n_offscr); end
        n_vec++; if (last_x !== 159 || last_y !== 119) begin
            n_err++; $display("FAIL clip_last: got (%0d,%0d) expected (159,119)", last_x, last_y); end
        n_vec++; if (n_slot_err !== 0) begin n_err++; $display("FAIL clip_slots: got %0d expected 0", n_slot_err); end
        n_vec++; if (done_cyc !== 259) begin n_err++; $display("FAIL clip_done: got %0d expected 259", done_cyc); end
        run_a(160, 0, 0, 0, 0, 1'b0, 270);
        n_vec++; if (n_plot !== 0) begin n_err++; $display("FAIL offscreen_count: got %0d expected 0", n_plot); end
        n_vec++; if (done_cyc !== 259 || n_busy !== 258) begin
            n_err++; $display("FAIL offscreen_done: got c%0d busy%0d expected c259 busy258", done_cyc, n_busy); end
    endtask

    task automatic test_small_latency();
        int k;
        n_plot = 0; n_slot_err = 0; n_addr_err = 0; done_cyc = -1; n_done = 0;
        @(negedge clk);
        bus_b.x_in = 8'd0; bus_b.y_in = 7'd0; bus_b.start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (cyc <= 8 && bus_b.rom_addr !== 3'(cyc - 1)) n_addr_err++;
            k = cyc - 5;
            if (k >= 0 && k < 8) begin
                if (bus_b.plot !== 1'b1 || bus_b.vga_x !== 8'(k % 4) ||
                    bus_b.vga_y !== 7'(k / 4) || bus_b.vga_colour !== 3'(k))
                    n_slot_err++;
            end else if (bus_b.plot !== 1'b0) begin
                n_slot_err++;
            end
            if (bus_b.plot === 1'b1) n_plot++;
            if (bus_b.done === 1'b1) begin n_done++; done_cyc = cyc; end
        end
        n_vec++; if (n_addr_err !== 0) begin n_err++; $display("FAIL lat3_addr: got %0d bad addrs expected 0", n_addr_err); end
        n_vec++; if (n_plot !== 8) begin n_err++; $display("FAIL lat3_count: got %0d expected 8", n_plot); end
        n_vec++; if (n_slot_err !== 0) begin n_err++; $display("FAIL lat3_slots: got %0d expected 0", n_slot_err); end
        n_vec++; if (done_cyc !== 13 || n_done !== 1) begin
            n_err++; $display("FAIL lat3_done: got c%0d x%0d expected c13 x1", done_cyc, n_done); end
    endtask

    task automatic test_ignore_inputs();
        rom_mode = 0;
        run_a(10, 20, 50, 60, 0, 1'b0, 300);
        n_vec++; if (n_plot !== 256 || n_slot_err !== 0) begin
            n_err++; $display("FAIL ignore_draw: got %0d plots %0d bad expected 256 0", n_plot, n_slot_err); end
        n_vec++; if (last_x !== 25 || last_y !== 35) begin
            n_err++; $display("FAIL ignore_last: got (%0d,%0d) expected (25,35)", last_x, last_y); end
        n_vec++; if (done_cyc !== 259 || n_done !== 1 || n_busy !== 258) begin
            n_err++; $display("FAIL ignore_done: got c%0d x%0d busy%0d expected c259 x1 busy258", done_cyc, n_done, n_busy); end
    endtask

    task automatic test_back_to_back();
        rom_mode = 0;
        run_a(10, 20, 259, 0, 0, 1'b0, 300);
        n_vec++; if (n_done !== 1 || n_busy !== 258 || n_plot !== 256) begin
            n_err++; $display("FAIL start_in_done: got done%0d busy%0d plots%0d expected 1 258 256", n_done, n_busy, n_plot); end
        run_a(10, 20, 260, 0, 0, 1'b1, 540);
        n_vec++; if (n_done !== 2 || done_cyc !== 519) begin
            n_err++; $display("FAIL start_after_done: got done%0d last c%0d expected 2 c519", n_done, done_cyc); end
        n_vec++; if (n_plot !== 512 || n_slot_err !== 0) begin
            n_err++; $display("FAIL b2b_draw: got %0d plots %0d bad expected 512 0", n_plot, n_slot_err); end
    endtask

    task automatic test_reset_abort();
        rom_mode = 0;
        run_a(10, 20, 0, 0, 100, 1'b0, 300);
        n_vec++; if (async_plot !== 1'b0 || async_busy !== 1'b0) begin
            n_err++; $display("FAIL abort_async: got plot %b busy %b expected 0 0", async_plot, async_busy); end
        n_vec++; if (n_plot !== 97 || n_slot_err !== 0) begin
            n_err++; $display("FAIL abort_plots: got %0d plots %0d bad expected 97 0", n_plot, n_slot_err); end
        n_vec++; if (n_done !== 0 || busy_last !== 99) begin
            n_err++; $display("FAIL abort_done: got done%0d busy_last%0d expected 0 99", n_done, busy_last); end
        run_a(0, 0, 0, 0, 0, 1'b0, 270);
        n_vec++; if (first_x !== 0 || first_y !== 0 || first_cyc !== 3) begin
            n_err++; $display("FAIL restart_first: got c%0d (%0d,%0d) expected c3 (0,0)", first_cyc, first_x, first_y); end
        n_vec++; if (n_plot !== 256 || n_slot_err !== 0 || done_cyc !== 259) begin
            n_err++; $display("FAIL restart_draw: got %0d plots %0d bad done c%0d expected 256 0 c259", n_plot, n_slot_err, done_cyc); end
    endtask

    initial begin
        test_reset_state();
        test_solid();
        test_transparency();
        test_clipping();
        test_small_latency();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
